axi_wr_issue: RTL and testbench
===============================

Name: axi_wr_issue

Overview:
- Downstream consumer of the MIG-side synchronous write FIFO.
- Pops one packed write command per transaction: {wstrb, addr, data}.
- Issues each command as a single-beat AXI4 write (AW, W, B) toward the MIG AXI slave.
- Reports completion count and sticky error/timeout status to the CPU-side status logic.

Parameters:
- AXAW, 32, AXI address width.
- AXDW, 32, AXI data width; power of two, at least 8.
- TOVAL, 1023, B-channel timeout in cycles; a counter value, at least 1.
- FIFODW, AXDW/8+AXAW+AXDW, FIFO entry width (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rqempty  in  1  FIFO empty flag.
- rdata  in  FIFODW  FIFO head entry; valid while rqempty=0. Packing: [FIFODW-1 -: AXDW/8]=wstrb, next AXAW bits=addr, [AXDW-1:0]=data.
- rnext  out  1  FIFO pop strobe, one cycle per entry.
- awaddr  out  AXAW  AXI write address.
- awlen  out  8  constant 0.
- awsize  out  3  constant log2(AXDW/8).
- awburst  out  2  constant 2'b01 (INCR).
- awvalid  out  1  address valid.
- awready  in  1  address ready.
- wdata  out  AXDW  write data.
- wstrb  out  AXDW/8  byte strobes.
- wlast  out  1  equals wvalid.
- wvalid  out  1  data valid.
- wready  in  1  data ready.
- bresp  in  2  write response.
- bvalid  in  1  response valid.
- bready  out  1  response ready.
- busy  out  1  state != IDLE.
- wr_cnt  out  16  completed writes; wraps at 16'hFFFF->0.
- err_resp  out  1  sticky: a bresp != 2'b00 was received.
- err_tout  out  1  sticky: a B timeout occurred.

Behaviour:
- Reset (rst high at posedge): state=IDLE; awvalid=wvalid=bready=0; rnext=0; wr_cnt=0; err_resp=err_tout=0. awaddr, wdata and wstrb reset to 0.
- Reset mid-transaction: valids drop at the next edge; the in-flight entry is discarded and not counted.
- rnext is combinational: 1 iff state==IDLE && !rqempty && !rst.
- IDLE:
  - When rnext=1, capture rdata fields into awaddr, wdata and wstrb.
  - Set awvalid=1 and wvalid=1 at the same edge.
  - Go to ISSUE.
- ISSUE:
  - awvalid is held until sampled with awready=1, then cleared.
  - wvalid is handled the same way with wready, independently of awvalid.
  - The AW and W handshakes may complete in either order or in the same cycle.
  - When both handshakes are done, set bready=1 and go to RESP. This may happen on the same edge as the last handshake.
  - Payload registers must stay stable while their valid is high (AXI rule).
- RESP:
  - The timeout counter clears on entry and increments every cycle bvalid=0.
  - On bvalid=1 (bready is 1):
    - wr_cnt+1.
    - If bresp != 0, set err_resp=1.
    - bready=0; go to IDLE.
  - If the counter reaches TOVAL with no bvalid: err_tout=1, bready=0, go to IDLE, and wr_cnt is not incremented.
  - A bvalid on the same cycle as the counter reaching TOVAL counts as a response, not a timeout.
- Throughput: minimum 3 cycles per write (IDLE, ISSUE, RESP) with zero-wait slave.
- Single outstanding transaction; no new pop until B completes or times out.
- FIFO empty: remain in IDLE and rnext stays 0.
- awvalid, wvalid and bready are driven only from registers, with no combinational path from any ready input.
- Sticky flags clear only on rst.

Decomposition:
- Shared package `axi_pkg`:
  - FSM state encoding: IDLE=2'd0, ISSUE=2'd1, RESP=2'd2.
  - AXI constants: RESP_OKAY=2'b00, BURST_INCR=2'b01.
  - Helper function for awsize from data width.
- No sub-module is natural. The timeout counter is local to the module, and the FIFO stays a separate instance in the parent.

Test Plan:
- Zero-wait slave, FIFO preloaded with 3 entries (addr 0x100/0x104/0x108, data 0xA5A5A5A5.., wstrb 4'hF).
  - Required: 3 rnext pulses, each AW/W accepted the cycle after its pop, wr_cnt=3.
  - Required: 9 cycles from the first rnext to the last B, and err flags 0.
- Skewed handshakes: awready delayed 4 cycles with wready immediate, then the reverse.
  - Required: each valid held with stable payload until its own handshake, bready rises only after both, and wr_cnt increments once per write.
- Error response: slave returns bresp=2'b10.
  - Required: err_resp=1, wr_cnt still increments, err_resp stays 1 after a later OKAY write.
- Timeout: TOVAL=8, slave never asserts bvalid.
  - Required: err_tout=1 exactly 8 cycles after entering RESP, return to IDLE, wr_cnt unchanged, next FIFO entry popped.
- Reset mid-ISSUE: assert rst for 1 cycle while awvalid=1.
  - Required: all valids 0, wr_cnt=0, state IDLE on the next cycle, and no extra rnext during reset.
- Empty FIFO: rqempty=1 for 20 cycles.
  - Required: rnext=0, busy=0, no AXI valids asserted.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI write-issue definitions: FSM encoding, AXI field constants and a size helper.
package axi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] BURST_INCR = 2'b01;

   // AXI size code for a full-width beat: log2 of the bus width in bytes.
   function automatic logic [2:0] axsize(input int dw);
      logic [2:0] s;
      s = 3'd0;
      for (int i = 0; i < 8; i++)
         if ((8 << i) == dw) s = 3'(i);
      return s;
   endfunction

endpackage

// File: rtl/axi_wr_issue.sv
// Pops one {wstrb, addr, data} FIFO entry and issues it as a single-beat AXI4 write; >=3 cycles/write.
// One transaction outstanding; AW/W valids hold until their own ready, B is bounded by a TOVAL-cycle timeout.
module axi_wr_issue
   import axi_pkg::*;
#(
   parameter int AXAW   = 32,
   parameter int AXDW   = 32,
   parameter int TOVAL  = 1023,
   parameter int FIFODW = AXDW/8 + AXAW + AXDW
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rqempty,
   input  logic [FIFODW-1:0]   rdata,
   output logic                rnext,
   output logic [AXAW-1:0]     awaddr,
   output logic [7:0]          awlen,
   output logic [2:0]          awsize,
   output logic [1:0]          awburst,
   output logic                awvalid,
   input  logic                awready,
   output logic [AXDW-1:0]     wdata,
   output logic [AXDW/8-1:0]   wstrb,
   output logic                wlast,
   output logic                wvalid,
   input  logic                wready,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready,
   output logic                busy,
   output logic [15:0]         wr_cnt,
   output logic                err_resp,
   output logic                err_tout
);

   localparam int SW = AXDW/8;
   localparam int TW = $clog2(TOVAL + 1);

   state_t         state;
   logic [TW-1:0]  tcnt;
   logic           aw_hold;
   logic           w_hold;

   assign rnext   = (state == IDLE) && !rqempty && !rst;
   assign awlen   = 8'd0;
   assign awsize  = axsize(AXDW);
   assign awburst = BURST_INCR;
   assign wlast   = wvalid;
   assign busy    = (state != IDLE);

   // A valid survives the edge only if its ready was not sampled high.
   always_comb begin
      aw_hold = awvalid && !awready;
      w_hold  = wvalid && !wready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         awvalid  <= 1'b0;
         wvalid   <= 1'b0;
         bready   <= 1'b0;
         awaddr   <= '0;
         wdata    <= '0;
         wstrb    <= '0;
         tcnt     <= '0;
         wr_cnt   <= 16'd0;
         err_resp <= 1'b0;
         err_tout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!rqempty) begin
                  wstrb   <= rdata[FIFODW-1 -: SW];
                  awaddr  <= rdata[AXDW +: AXAW];
                  wdata   <= rdata[AXDW-1:0];
                  awvalid <= 1'b1;
                  wvalid  <= 1'b1;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               awvalid <= aw_hold;
               wvalid  <= w_hold;
               if (!aw_hold && !w_hold) begin
                  bready <= 1'b1;
                  tcnt   <= '0;
                  state  <= RESP;
               end
            end
            RESP: begin
               // A response arriving on the final timeout cycle still wins.
               if (bvalid) begin
                  wr_cnt <= wr_cnt + 16'd1;
                  if (bresp != RESP_OKAY) err_resp <= 1'b1;
                  bready <= 1'b0;
                  state  <= IDLE;
               end else if (tcnt == TW'(TOVAL - 1)) begin
                  err_tout <= 1'b1;
                  bready   <= 1'b0;
                  state    <= IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_wr_issue.sv
// Bench for axi_wr_issue: queue-modelled FIFO and AXI slave, scenario tasks with inline checks.
module tb_axi_wr_issue;

   localparam int AXAW   = 32;
   localparam int AXDW   = 32;
   localparam int SW     = AXDW/8;
   localparam int TOVAL  = 8;
   localparam int FIFODW = SW + AXAW + AXDW;

   typedef struct packed {
      logic [SW-1:0]   strb;
      logic [AXAW-1:0] addr;
      logic [AXDW-1:0] data;
   } ent_t;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                rqempty = 1'b1;
   logic [FIFODW-1:0]   rdata = '0;
   logic                rnext;
   logic [AXAW-1:0]     awaddr;
   logic [7:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                awvalid;
   logic                awready = 1'b0;
   logic [AXDW-1:0]     wdata;
   logic [SW-1:0]       wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready = 1'b0;
   logic [1:0]          bresp = 2'b00;
   logic                bvalid = 1'b0;
   logic                bready;
   logic                busy;
   logic [15:0]         wr_cnt;
   logic                err_resp;
   logic                err_tout;

   axi_wr_issue #(.AXAW(AXAW), .AXDW(AXDW), .TOVAL(TOVAL)) dut (
      .clk(clk), .rst(rst), .rqempty(rqempty), .rdata(rdata), .rnext(rnext),
      .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
      .wlast(wlast), .wvalid(wvalid), .wready(wready), .bresp(bresp),
      .bvalid(bvalid), .bready(bready), .busy(busy), .wr_cnt(wr_cnt),
      .err_resp(err_resp), .err_tout(err_tout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference state: FIFO contents, slave knobs, observed events.
   ent_t            fq[$];
   logic [AXAW-1:0] aw_q[$];
   logic [SW+AXDW-1:0] w_q[$];
   int              pop_cyc[$], aw_cyc[$], w_cyc[$], b_cyc[$];
   int              aw_dly = 0, w_dly = 0, b_dly = 0;
   bit              b_never = 1'b0;
   logic [1:0]      b_resp_cfg = 2'b00;
   int              aw_wait = 0, w_wait = 0, b_wait = 0;
   bit              aw_done = 0, w_done = 0, b_pend = 0;
   bit              pop_p = 0, aw_p = 0, w_p = 0, b_p = 0;
   bit              pav = 0, pwv = 0;
   logic [AXAW-1:0] pa = '0;
   logic [SW+AXDW-1:0] pw = '0;
   int              n_tout = 0, stab_err = 0, order_err = 0;
   int              exp_cnt = 0;
   bit              exp_err = 0, exp_tout = 0;

   // Slave/FIFO model: events predicted at one falling edge happen at the next rising edge
   // and are applied at the falling edge after it.
   always @(negedge clk) begin
      if (pop_p) void'(fq.pop_front());
      rqempty = (fq.size() == 0);
      if (fq.size() != 0) rdata = fq[0];
      if (!rst && awvalid && pav && !aw_p && awaddr !== pa) stab_err++;
      if (!rst && wvalid && pwv && !w_p && {wstrb, wdata} !== pw) stab_err++;
      pav = awvalid; pa = awaddr; pwv = wvalid; pw = {wstrb, wdata};
      if (aw_p) begin aw_done = 1'b1; aw_wait = 0; end
      if (w_p)  begin w_done = 1'b1;  w_wait = 0; end
      if (b_p)  begin b_pend = 1'b0;  b_wait = 0; end
      pop_p = 0; aw_p = 0; w_p = 0; b_p = 0;
      if (rst) begin
         aw_done = 0; w_done = 0; b_pend = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
         pav = 0; pwv = 0; awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
      end else begin
         if (aw_done && w_done) begin aw_done = 0; w_done = 0; b_pend = 1; b_wait = 0; end
         if (b_pend && b_never && !bready) begin b_pend = 0; n_tout++; end
         if (bready && !b_pend) order_err++;
         if (awvalid) begin awready = (aw_wait >= aw_dly); aw_wait++; end
         else begin awready = 1'b0; aw_wait = 0; end
         if (wvalid) begin wready = (w_wait >= w_dly); w_wait++; end
         else begin wready = 1'b0; w_wait = 0; end
         if (b_pend && !b_never) begin
            bvalid = (b_wait >= b_dly); bresp = bvalid ? b_resp_cfg : 2'b00; b_wait++;
         end else begin
            bvalid = 1'b0; bresp = 2'b00;
         end
         pop_p = rnext;
         if (pop_p) pop_cyc.push_back(cyc);
         aw_p = awvalid && awready;
         if (aw_p) begin aw_q.push_back(awaddr); aw_cyc.push_back(cyc); end
         w_p = wvalid && wready;
         if (w_p) begin w_q.push_back({wstrb, wdata}); w_cyc.push_back(cyc); end
         b_p = bvalid && bready;
         if (b_p) b_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic drv();
      @(posedge clk); #2;
   endtask

   task automatic push(input ent_t e);
      fq.push_back(e);
      rqempty = 1'b0;
      rdata = fq[0];
   endtask

   task automatic clear_obs();
      aw_q.delete(); w_q.delete(); pop_cyc.delete(); aw_cyc.delete(); w_cyc.delete(); b_cyc.delete();
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         tick();
         if (fq.size() == 0 && !busy && !pop_p) begin ok = 1'b1; break; end
      end
   endtask

   function automatic ent_t rand_ent();
      ent_t e;
      e.strb = SW'($urandom_range(1, (1 << SW) - 1));
      e.addr = AXAW'($urandom) & ~AXAW'(3);
      e.data = AXDW'($urandom);
      return e;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({awvalid, wvalid, bready, rnext, busy, err_resp, err_tout} !== 7'b0) begin
         errors++; $display("FAIL reset_flags got %b want 0", {awvalid, wvalid, bready, rnext, busy, err_resp, err_tout});
      end
      checks++;
      if ({wr_cnt, awaddr, wdata, wstrb} !== '0) begin
         errors++; $display("FAIL reset_regs got cnt=%0h addr=%0h data=%0h strb=%0h want 0", wr_cnt, awaddr, wdata, wstrb);
      end
      checks++;
      if (awlen !== 8'd0 || awsize !== 3'd2 || awburst !== 2'b01 || wlast !== wvalid) begin
         errors++; $display("FAIL consts got len=%0h size=%0h burst=%0h want 0/2/1", awlen, awsize, awburst);
      end
      drv(); rst = 1'b0;
   endtask

   task automatic test_reset_mid_issue();
      ent_t e1, e2;
      bit ok;
      clear_obs();
      e1 = rand_ent(); e2 = rand_ent();
      aw_dly = 100; w_dly = 100; b_dly = 0;
      drv(); push(e1); push(e2);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin tick(); if (awvalid) begin ok = 1'b1; break; end end
      checks++;
      if (!ok) begin errors++; $display("FAIL mid_awvalid got 0 want 1"); end
      drv(); rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (rnext !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL rnext_in_reset got rnext=%b busy=%b want 0/0", rnext, busy);
      end
      aw_dly = 0; w_dly = 0;
      #1 rst = 1'b0;
      tick();
      checks++;
      if ({awvalid, wvalid, bready} !== 3'b0 || wr_cnt !== 16'd0) begin
         errors++; $display("FAIL mid_reset got v=%b cnt=%0d want 0/0", {awvalid, wvalid, bready}, wr_cnt);
      end
      wait_idle(ok);
      exp_cnt = 1;
      checks++;
      if (!ok || wr_cnt !== 16'(exp_cnt) || pop_cyc.size() != 2) begin
         errors++; $display("FAIL mid_complete got cnt=%0d pops=%0d want %0d/2", wr_cnt, pop_cyc.size(), exp_cnt);
      end
      checks++;
      if (aw_q.size() != 1 || w_q.size() != 1 || aw_q[0] !== e2.addr || w_q[0] !== {e2.strb, e2.data}) begin
         errors++; $display("FAIL mid_payload got n=%0d want 1 entry addr %0h", aw_q.size(), e2.addr);
      end
   endtask

   task automatic test_zero_wait();
      ent_t e[3];
      bit ok;
      clear_obs();
      aw_dly = 0; w_dly = 0; b_dly = 0; b_resp_cfg = 2'b00;
      for (int i = 0; i < 3; i++) begin
         e[i].addr = 32'h100 + 32'(4 * i); e[i].data = 32'hA5A5A5A5; e[i].strb = 4'hF;
      end
      drv(); for (int i = 0; i < 3; i++) push(e[i]);
      wait_idle(ok);
      exp_cnt += 3;
      checks++;
      if (!ok || pop_cyc.size() != 3 || aw_cyc.size() != 3 || w_cyc.size() != 3 || b_cyc.size() != 3) begin
         errors++; $display("FAIL zw_counts got pops=%0d aw=%0d b=%0d want 3", pop_cyc.size(), aw_cyc.size(), b_cyc.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (aw_cyc[i] != pop_cyc[i] + 1 || w_cyc[i] != pop_cyc[i] + 1 || aw_q[i] !== e[i].addr || w_q[i] !== {e[i].strb, e[i].data}) begin
               errors++; $display("FAIL zw_accept%0d got aw@+%0d w@+%0d addr=%0h want +1/+1 addr=%0h", i, aw_cyc[i] - pop_cyc[i], w_cyc[i] - pop_cyc[i], aw_q[i], e[i].addr);
            end
         end
         checks++;
         if (b_cyc[2] - pop_cyc[0] + 1 != 9) begin
            errors++; $display("FAIL zw_span got %0d want 9", b_cyc[2] - pop_cyc[0] + 1);
         end
      end
      checks++;
      if (wr_cnt !== 16'(exp_cnt) || err_resp !== 1'b0 || err_tout !== 1'b0) begin
         errors++; $display("FAIL zw_status got cnt=%0d er=%b et=%b want %0d/0/0", wr_cnt, err_resp, err_tout, exp_cnt);
      end
   endtask

   task automatic test_skew();
      ent_t e;
      bit ok;
      for (int k = 0; k < 2; k++) begin
         clear_obs();
         aw_dly = (k == 0) ? 4 : 0;
         w_dly  = (k == 0) ? 0 : 4;
         e = rand_ent();
         drv(); push(e);
         wait_idle(ok);
         exp_cnt++;
         checks++;
         if (!ok || pop_cyc.size() != 1 || aw_cyc.size() != 1 || w_cyc.size() != 1 || b_cyc.size() != 1) begin
            errors++; $display("FAIL skew%0d_counts got pops=%0d b=%0d want 1/1", k, pop_cyc.size(), b_cyc.size());
         end else begin
            checks++;
            if (aw_cyc[0] - pop_cyc[0] != 1 + aw_dly || w_cyc[0] - pop_cyc[0] != 1 + w_dly || b_cyc[0] <= aw_cyc[0] || b_cyc[0] <= w_cyc[0]) begin
               errors++; $display("FAIL skew%0d_timing got aw@+%0d w@+%0d b@+%0d want +%0d/+%0d", k, aw_cyc[0] - pop_cyc[0], w_cyc[0] - pop_cyc[0], b_cyc[0] - pop_cyc[0], 1 + aw_dly, 1 + w_dly);
            end
            checks++;
            if (aw_q[0] !== e.addr || w_q[0] !== {e.strb, e.data}) begin
               errors++; $display("FAIL skew%0d_payload got %0h/%0h want %0h/%0h", k, aw_q[0], w_q[0], e.addr, {e.strb, e.data});
            end
         end
         checks++;
         if (stab_err != 0 || order_err != 0 || wr_cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL skew%0d_rules got stab=%0d order=%0d cnt=%0d want 0/0/%0d", k, stab_err, order_err, wr_cnt, exp_cnt);
         end
      end
      aw_dly = 0; w_dly = 0;
   endtask

   task automatic test_err_resp();
      bit ok;
      b_resp_cfg = 2'b10;
      drv(); push(rand_ent());
      wait_idle(ok);
      exp_cnt++; exp_err = 1'b1;
      checks++;
      if (!ok || err_resp !== 1'b1 || wr_cnt !== 16'(exp_cnt)) begin
         errors++; $display("FAIL slverr got er=%b cnt=%0d want 1/%0d", err_resp, wr_cnt, exp_cnt);
      end
      b_resp_cfg = 2'b00;
      drv(); push(rand_ent());
      wait_idle(ok);
      exp_cnt++;
      checks++;
      if (!ok || err_resp !== 1'b1 || wr_cnt !== 16'(exp_cnt)) begin
         errors++; $display("FAIL err_sticky got er=%b cnt=%0d want 1/%0d", err_resp, wr_cnt, exp_cnt);
      end
   endtask

   task automatic test_timeout();
      int resp_c, tout_c;
      bit ok;
      clear_obs();
      b_never = 1'b1;
      drv(); push(rand_ent()); push(rand_ent());
      resp_c = -1; tout_c = -1;
      for (int i = 0; i < 200 && tout_c < 0; i++) begin
         tick();
         if (bready && resp_c < 0) resp_c = cyc;
         if (err_tout) tout_c = cyc;
      end
      b_never = 1'b0;
      exp_tout = 1'b1;
      checks++;
      if (tout_c < 0 || resp_c < 0 || tout_c - resp_c != TOVAL) begin
         errors++; $display("FAIL tout_delay got %0d want %0d", tout_c - resp_c, TOVAL);
      end
      checks++;
      if (busy !== 1'b0 || bready !== 1'b0 || wr_cnt !== 16'(exp_cnt)) begin
         errors++; $display("FAIL tout_state got busy=%b bready=%b cnt=%0d want 0/0/%0d", busy, bready, wr_cnt, exp_cnt);
      end
      wait_idle(ok);
      exp_cnt++;
      checks++;
      if (!ok || pop_cyc.size() != 2 || wr_cnt !== 16'(exp_cnt) || err_tout !== 1'b1 || n_tout != 1) begin
         errors++; $display("FAIL tout_next got pops=%0d cnt=%0d et=%b want 2/%0d/1", pop_cyc.size(), wr_cnt, err_tout, exp_cnt);
      end
   endtask

   task automatic test_empty();
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if ({rnext, busy, awvalid, wvalid, bready} !== 5'b0) begin
            errors++; $display("FAIL empty%0d got %b want 0", i, {rnext, busy, awvalid, wvalid, bready});
         end
      end
   endtask

   task automatic test_back_to_back();
      ent_t e;
      bit ok;
      for (int n = 0; n < 12; n++) begin
         clear_obs();
         aw_dly = $urandom_range(0, 3);
         w_dly  = $urandom_range(0, 3);
         b_dly  = $urandom_range(0, 5);
         b_resp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         e = rand_ent();
         drv(); push(e);
         wait_idle(ok);
         exp_cnt++;
         if (b_resp_cfg != 2'b00) exp_err = 1'b1;
         checks++;
         if (!ok || aw_q.size() != 1 || w_q.size() != 1 || aw_q[0] !== e.addr || w_q[0] !== {e.strb, e.data}) begin
            errors++; $display("FAIL rnd%0d_payload got n=%0d want addr %0h data %0h", n, aw_q.size(), e.addr, {e.strb, e.data});
         end
         checks++;
         if (wr_cnt !== 16'(exp_cnt) || err_resp !== exp_err || err_tout !== exp_tout || stab_err != 0 || order_err != 0) begin
            errors++; $display("FAIL rnd%0d_status got cnt=%0d er=%b et=%b stab=%0d order=%0d want %0d/%b/%b/0/0", n, wr_cnt, err_resp, err_tout, stab_err, order_err, exp_cnt, exp_err, exp_tout);
         end
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_issue();
      test_zero_wait();
      test_skew();
      test_err_resp();
      test_timeout();
      test_empty();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
